// File: rtl/pet_stats.sv
// pet_stats: five need levels, AWAKE/SLEEP/DEAD state and status byte,
// driven by UART command bytes and a real-time tick.
module pet_stats #(
  parameter int TICK_CYCLES = 27000000,
  parameter int DECAY_TICKS = 10,
  parameter int GRACE_TICKS = 5,
  parameter int INIT_LEVEL  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  output logic [4:0] hunger,
  output logic [4:0] happiness,
  output logic [4:0] hygiene,
  output logic [4:0] energy,
  output logic [4:0] social,
  output logic       is_sleeping,
  output logic [7:0] status,
  output logic       cmd_ack,
  output logic       cmd_err
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int GW = $clog2(GRACE_TICKS + 1);
  localparam logic [4:0] INIT = 5'(INIT_LEVEL);
  localparam int HU = 0;
  localparam int HA = 1;
  localparam int HY = 2;
  localparam int EN = 3;
  localparam int SO = 4;

  typedef enum logic [1:0] {
    AWAKE,
    SLEEP,
    DEAD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] decay_q, decay_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [GW-1:0] grace_inc;
  logic [7:0]    prev_q;
  logic [7:0]    uc;
  logic [4:0]    need_q [5];
  logic [4:0]    need_d [5];
  logic          tick, decay, new_byte, restart;
  logic          crit_q, crit_d, ack_d, err_d;

  function automatic logic [4:0] add(
    input logic [4:0]        a,
    input logic signed [5:0] d
  );
    logic signed [5:0] v;
    v = $signed({1'b0, a}) + d;
    if (v < 0) return 5'd0;
    if (v > 6'sd15) return 5'd15;
    return v[4:0];
  endfunction

  assign hunger    = need_q[HU];
  assign happiness = need_q[HA];
  assign hygiene   = need_q[HY];
  assign energy    = need_q[EN];
  assign social    = need_q[SO];

  // Command decode, decay, grace/death and auto-wake in one next-state pass
  always_comb begin
    tick     = (tick_q == TW'(TICK_CYCLES - 1));
    decay    = tick && (decay_q == DW'(DECAY_TICKS - 1));
    new_byte = (cmd_byte != 8'h00) && (cmd_byte != prev_q);
    uc = (cmd_byte >= "a" && cmd_byte <= "z") ?
         cmd_byte - 8'd32 : cmd_byte;
    crit_q = 1'b0;
    for (int i = 0; i < 5; i++) begin
      need_d[i] = need_q[i];
      crit_q    = crit_q | (need_q[i] == 5'd15);
    end
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    restart   = 1'b0;
    tick_d    = tick ? '0 : tick_q + 1'b1;
    decay_d   = decay_q;
    if (tick) decay_d = decay ? '0 : decay_q + 1'b1;
    grace_d   = grace_q;
    grace_inc = grace_q + 1'b1;

    if (new_byte) begin
      err_d = 1'b1;
      case (state_q)
        AWAKE: begin
          unique case (1'b1)
            (uc == "F"): begin
              need_d[HU] = add(need_q[HU], -6'sd4);
              ack_d = 1'b1;
            end
            (uc == "P"): begin
              need_d[HA] = add(need_q[HA], -6'sd4);
              need_d[EN] = add(need_q[EN], 6'sd2);
              ack_d = 1'b1;
            end
            (uc == "B"): begin
              need_d[HY] = 5'd0;
              ack_d = 1'b1;
            end
            (uc == "T"): begin
              need_d[SO] = add(need_q[SO], -6'sd4);
              ack_d = 1'b1;
            end
            (uc == "S"): begin
              state_d = SLEEP;
              ack_d = 1'b1;
            end
            default: ;
          endcase
        end
        SLEEP: begin
          if (uc == "W") begin
            state_d = AWAKE;
            ack_d = 1'b1;
          end
        end
        DEAD: begin
          if (uc == "R") begin
            for (int i = 0; i < 5; i++) need_d[i] = INIT;
            state_d = AWAKE;
            restart = 1'b1;
            ack_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (ack_d) err_d = 1'b0;
    end

    // Decay acts on the post-command levels and state
    if (decay && !restart) begin
      case (state_d)
        AWAKE: begin
          for (int i = 0; i < 5; i++)
            need_d[i] = add(need_d[i], 6'sd1);
        end
        SLEEP: begin
          need_d[EN] = add(need_d[EN], -6'sd2);
          need_d[HU] = add(need_d[HU], 6'sd1);
        end
        default: ;
      endcase
    end

    if (restart) begin
      tick_d  = '0;
      decay_d = '0;
      grace_d = '0;
    end else if (state_q != DEAD) begin
      if (!crit_q) grace_d = '0;
      else if (tick) grace_d = grace_inc;
      if (crit_q && tick && grace_inc == GW'(GRACE_TICKS))
        state_d = DEAD;
      else if (state_q == SLEEP && need_q[EN] == 5'd0)
        state_d = AWAKE;
    end

    crit_d = 1'b0;
    for (int i = 0; i < 5; i++)
      crit_d = crit_d | (need_d[i] == 5'd15);
  end

  // State, counters, levels and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AWAKE;
      tick_q      <= '0;
      decay_q     <= '0;
      grace_q     <= '0;
      prev_q      <= 8'h00;
      for (int i = 0; i < 5; i++) need_q[i] <= INIT;
      is_sleeping <= 1'b0;
      status      <= 8'h00;
      cmd_ack     <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      decay_q     <= decay_d;
      grace_q     <= grace_d;
      prev_q      <= cmd_byte;
      for (int i = 0; i < 5; i++) need_q[i] <= need_d[i];
      is_sleeping <= (state_d == SLEEP);
      status      <= {5'b0, crit_d, state_d == DEAD,
                      state_d == SLEEP};
      cmd_ack     <= ack_d;
      cmd_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_pet_stats.sv
// tb_pet_stats: directed checks of pet_stats with a short tick
// (4 cycles), decay every 2 ticks, death after 3 critical ticks.
module tb_pet_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_byte;
  logic [4:0] hunger, happiness, hygiene, energy, social;
  logic       is_sleeping, cmd_ack, cmd_err;
  logic [7:0] status;

  pet_stats #(
    .TICK_CYCLES(4),
    .DECAY_TICKS(2),
    .GRACE_TICKS(3),
    .INIT_LEVEL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_byte(cmd_byte),
    .hunger(hunger),
    .happiness(happiness),
    .hygiene(hygiene),
    .energy(energy),
    .social(social),
    .is_sleeping(is_sleeping),
    .status(status),
    .cmd_ack(cmd_ack),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  int acks, errs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(
    input logic [4:0] a, b, c, d, e);
    return {7'd0, a, b, c, d, e};
  endfunction

  task automatic needs_is(input string tag,
                          input logic [4:0] a, b, c, d, e);
    chk(tag, pk(hunger, happiness, hygiene, energy, social),
        pk(a, b, c, d, e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto(input int t);
    while (edge_n < t) step();
  endtask

  task automatic do_reset(input logic [7:0] c);
    rst = 1'b1;
    cmd_byte = c;
    step();
    step();
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_byte = 8'h00;
    do_reset(8'h00);
    needs_is("reset_needs", 5'd4, 5'd4, 5'd4, 5'd4, 5'd4);
    chk("reset_status", 32'(status), 32'h0);
    chk("reset_flags", 32'({is_sleeping, cmd_ack, cmd_err}), 32'h0);

    // Held 'F' gives one event, then normal decay
    cmd_byte = "F";
    step();
    chk("f_hunger", 32'(hunger), 32'd0);
    acks = int'(cmd_ack);
    errs = int'(cmd_err);
    repeat (19) begin
      step();
      acks += int'(cmd_ack);
      errs += int'(cmd_err);
    end
    chk("f_one_ack", 32'(acks), 32'd1);
    chk("f_no_err", 32'(errs), 32'd0);
    needs_is("f_decay", 5'd2, 5'd6, 5'd6, 5'd6, 5'd6);

    // 'T' twice separated by idle, floor at 0
    cmd_byte = "T";
    step();
    acks = int'(cmd_ack);
    cmd_byte = 8'h00;
    step();
    acks += int'(cmd_ack);
    cmd_byte = "T";
    step();
    acks += int'(cmd_ack);
    chk("t_two_acks", 32'(acks), 32'd2);
    needs_is("t_floor", 5'd2, 5'd6, 5'd6, 5'd6, 5'd0);
    cmd_byte = 8'h00;
    goto(24);
    repeat (3) begin
      cmd_byte = "P";
      step();
      cmd_byte = 8'h00;
      step();
    end
    goto(32);
    needs_is("p_setup", 5'd4, 5'd1, 5'd8, 5'd14, 5'd2);
    cmd_byte = "P";
    step();
    chk("p_ack", 32'(cmd_ack), 32'd1);
    needs_is("p_sat", 5'd4, 5'd0, 5'd8, 5'd15, 5'd2);
    chk("p_crit", 32'(status), 32'h04);

    // Sleep, illegal command, sleep decay, auto wake
    do_reset(8'h00);
    cmd_byte = "S";
    step();
    chk("s_sleep", 32'(is_sleeping), 32'd1);
    chk("s_status", 32'(status), 32'h01);
    cmd_byte = "F";
    step();
    chk("s_f_err", 32'({cmd_ack, cmd_err}), 32'h1);
    chk("s_f_hunger", 32'(hunger), 32'd4);
    cmd_byte = 8'h00;
    goto(8);
    needs_is("s_decay1", 5'd5, 5'd4, 5'd4, 5'd2, 5'd4);
    goto(16);
    needs_is("s_decay2", 5'd6, 5'd4, 5'd4, 5'd0, 5'd4);
    chk("s_still", 32'(status), 32'h01);
    step();
    chk("wake_flag", 32'(is_sleeping), 32'd0);
    chk("wake_status", 32'(status), 32'h00);
    chk("wake_no_ack", 32'(cmd_ack), 32'd0);

    // Neglect until critical, then grace, then death
    goto(87);
    chk("pre_crit", 32'(status), 32'h00);
    step();
    needs_is("crit_needs", 5'd15, 5'd13, 5'd13, 5'd9, 5'd13);
    chk("crit_status", 32'(status), 32'h04);
    goto(99);
    chk("grace2", 32'(status), 32'h04);
    step();
    chk("dead_status", 32'(status), 32'h06);
    needs_is("dead_needs", 5'd15, 5'd14, 5'd14, 5'd10, 5'd14);
    goto(106);
    needs_is("dead_frozen", 5'd15, 5'd14, 5'd14, 5'd10, 5'd14);
    cmd_byte = "F";
    step();
    chk("dead_f_err", 32'({cmd_ack, cmd_err}), 32'h1);
    chk("dead_f_hunger", 32'(hunger), 32'd15);
    cmd_byte = "r";
    step();
    chk("r_ack", 32'({cmd_ack, cmd_err}), 32'h2);
    needs_is("r_needs", 5'd4, 5'd4, 5'd4, 5'd4, 5'd4);
    chk("r_status", 32'(status), 32'h00);
    edge_n = 0;

    // Command and decay in the same cycle
    goto(23);
    chk("cd_setup", 32'(hunger), 32'd6);
    cmd_byte = "F";
    step();
    chk("cd_ack", 32'(cmd_ack), 32'd1);
    needs_is("cd_needs", 5'd3, 5'd7, 5'd7, 5'd7, 5'd7);

    // Reset while asleep with 'W' held
    do_reset(8'h00);
    cmd_byte = "S";
    step();
    chk("rs_sleep", 32'(is_sleeping), 32'd1);
    rst = 1'b1;
    cmd_byte = "W";
    step();
    step();
    needs_is("rs_needs", 5'd4, 5'd4, 5'd4, 5'd4, 5'd4);
    chk("rs_flags",
        32'({is_sleeping, cmd_ack, cmd_err, status}), 32'h0);
    rst = 1'b0;
    step();
    chk("rs_w_err", 32'({cmd_ack, cmd_err}), 32'h1);
    chk("rs_awake", 32'(is_sleeping), 32'd0);
    step();
    chk("rs_w_once", 32'({cmd_ack, cmd_err}), 32'h0);

    // Lowercase bath, then rejected bytes while awake
    cmd_byte = "b";
    step();
    chk("b_ack", 32'({cmd_ack, cmd_err}), 32'h2);
    chk("b_hygiene", 32'(hygiene), 32'd0);
    cmd_byte = "R";
    step();
    chk("r_awake_err", 32'({cmd_ack, cmd_err}), 32'h1);
    cmd_byte = "z";
    step();
    chk("unknown_err", 32'({cmd_ack, cmd_err}), 32'h1);
    cmd_byte = 8'h00;
    step();
    chk("idle_quiet", 32'({cmd_ack, cmd_err}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
